// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter sizing and
// fault-index width.
package reset_seq_pkg;

  localparam int unsigned FaultStageW = 3;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t StHold      = 3'd0;
  localparam seq_state_t StRelease   = 3'd1;
  localparam seq_state_t StWaitReady = 3'd2;
  localparam seq_state_t StSettle    = 3'd3;
  localparam seq_state_t StDone      = 3'd4;
  localparam seq_state_t StFault     = 3'd5;

  // Width needed to hold the largest count limit; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Shared up-counter with synchronous clear, count enable and a terminal compare.
module seq_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             at_limit_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all subsystem resets for a fixed period, then releases them one at a time,
// waiting for each stage's Ready (with timeout) and a settle gap before the next.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned STAGE_DELAY   = 256,
  parameter int unsigned READY_TIMEOUT = 65535
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   SoftReq,
  input  logic [NUM_STAGES-1:0]  Ready,
  output logic [NUM_STAGES-1:0]  StageReset,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Fault,
  output logic [FaultStageW-1:0] FaultStage
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGE_DELAY, READY_TIMEOUT);

  seq_state_t             state_q, state_d;
  logic [FaultStageW-1:0] idx_q, idx_d;
  logic [NUM_STAGES-1:0]  stage_reset_q, stage_reset_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fault_q, fault_d;
  logic [FaultStageW-1:0] fault_stage_q, fault_stage_d;
  logic                   soft_req_q;

  logic                   rst_req;
  logic                   tmr_clear;
  logic                   tmr_en;
  logic                   tmr_at_limit;
  logic [CntW-1:0]        tmr_limit;
  logic [7:0]             ready_pad;
  logic                   ready_sel;
  logic                   last_stage;
  logic [NUM_STAGES-1:0]  release_mask;

  assign rst_req      = !nReset || soft_req_q;
  // Padding to 8 bits lets the 3-bit index select without width games.
  assign ready_pad    = 8'(Ready);
  assign ready_sel    = ready_pad[idx_q];
  assign last_stage   = (idx_q == FaultStageW'(NUM_STAGES - 1));
  assign release_mask = NUM_STAGES'(1) << idx_q;

  always_comb begin
    tmr_limit = CntW'(HOLD_CYCLES - 1);
    case (state_q)
      StWaitReady: tmr_limit = CntW'(READY_TIMEOUT - 1);
      StSettle:    tmr_limit = CntW'(STAGE_DELAY - 1);
      default:     tmr_limit = CntW'(HOLD_CYCLES - 1);
    endcase
  end

  seq_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (Clk),
    .clear_i    (tmr_clear | rst_req),
    .en_i       (tmr_en),
    .limit_i    (tmr_limit),
    .at_limit_o (tmr_at_limit)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    busy_d        = busy_q;
    done_d        = done_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;
    case (state_q)
      StHold: begin
        if (tmr_at_limit) begin
          state_d   = StRelease;
          idx_d     = '0;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StRelease: begin
        stage_reset_d = stage_reset_q & ~release_mask;
        state_d       = StWaitReady;
        tmr_clear     = 1'b1;
      end
      StWaitReady: begin
        // Ready takes priority over a coincident timeout.
        if (ready_sel) begin
          tmr_clear = 1'b1;
          if (last_stage) begin
            state_d       = StDone;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            stage_reset_d = '0;
          end else begin
            state_d = StSettle;
          end
        end else if (tmr_at_limit) begin
          state_d = StFault;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StSettle: begin
        if (tmr_at_limit) begin
          idx_d     = idx_q + FaultStageW'(1);
          state_d   = StRelease;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      StFault: begin
        stage_reset_d = '1;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        fault_d       = 1'b1;
        fault_stage_d = idx_q;
      end
      default: begin
        state_d   = StHold;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    soft_req_q <= nReset ? SoftReq : 1'b0;
    if (rst_req) begin
      state_q       <= StHold;
      idx_q         <= '0;
      stage_reset_q <= '1;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign StageReset = stage_reset_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Fault      = fault_q;
  assign FaultStage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: expected outputs come from a timeline
// of release/ready/done/fault edges derived arithmetically from the stage rules.
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int HC = 16;
  localparam int SD = 4;
  localparam int RT = 32;
  localparam int NEVER = 1000;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       SoftReq = 1'b0;
  logic [3:0] Ready = 4'h0;
  logic [3:0] StageReset;
  logic       Busy, Done, Fault;
  logic [2:0] FaultStage;

  always #5 Clk = ~Clk;

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .HOLD_CYCLES   (HC),
    .STAGE_DELAY   (SD),
    .READY_TIMEOUT (RT)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .SoftReq    (SoftReq),
    .Ready      (Ready),
    .StageReset (StageReset),
    .Busy       (Busy),
    .Done       (Done),
    .Fault      (Fault),
    .FaultStage (FaultStage)
  );

  typedef struct packed {
    logic [3:0] sr;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] fs;
  } out_t;

  localparam out_t RstOut  = '{sr: 4'hF, busy: 1'b1, done: 1'b0, fault: 1'b0, fs: 3'd0};
  localparam out_t DoneOut = '{sr: 4'h0, busy: 1'b0, done: 1'b1, fault: 1'b0, fs: 3'd0};

  out_t got;
  assign got = {StageReset, Busy, Done, Fault, FaultStage};

  int errors = 0;
  int checks = 0;

  // Timeline of the current scenario, edges counted from the first qualifying edge.
  int dd [NS];
  int rel [NS];
  bit reached [NS];
  int done_edge, fault_edge, fault_stage;

  typedef struct {
    string      name;
    int         d [NS];
    logic       want_done;
    logic       want_fault;
    logic [2:0] want_fs;
  } vec_t;

  vec_t vecs [6];

  // d[i]: Ready[i] is driven high from edge rel[i]+d[i] onward (may precede release).
  task automatic plan(input int d0, input int d1, input int d2, input int d3);
    int r;
    int k;
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    done_edge = -1;
    fault_edge = -1;
    fault_stage = -1;
    for (int i = 0; i < NS; i++) begin
      reached[i] = 1'b0;
      rel[i] = 0;
    end
    r = HC + 1;
    for (int i = 0; i < NS; i++) begin
      reached[i] = 1'b1;
      rel[i] = r;
      if (dd[i] <= RT) begin
        k = r + ((dd[i] < 1) ? 1 : dd[i]);
        if (i == NS - 1) done_edge = k;
        else r = k + SD + 1;
      end else begin
        fault_stage = i;
        fault_edge = r + RT;
        break;
      end
    end
  endtask

  function automatic out_t expect_at(input int n);
    out_t e;
    e = RstOut;
    if (done_edge >= 0 && n >= done_edge) begin
      e = DoneOut;
    end else if (fault_edge >= 0 && n > fault_edge) begin
      e = '{sr: 4'hF, busy: 1'b0, done: 1'b0, fault: 1'b1, fs: 3'(fault_stage)};
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (reached[i] && n >= rel[i]) e.sr[i] = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [3:0] ready_at(input int n);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < NS; i++) begin
      if (reached[i] && n >= rel[i] + dd[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int end_edge();
    return (done_edge >= 0) ? done_edge + 3 : fault_edge + 4;
  endfunction

  task automatic check(input string name, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got sr=%b busy=%b done=%b fault=%b fs=%0d, want sr=%b busy=%b done=%b fault=%b fs=%0d",
               name, got.sr, got.busy, got.done, got.fault, got.fs,
               exp.sr, exp.busy, exp.done, exp.fault, exp.fs);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, actual, want);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge Clk);
    nReset = 1'b0;
    SoftReq = 1'b0;
    Ready = 4'h0;
    @(posedge Clk);
    #1 check({name, "_reset"}, RstOut);
  endtask

  // Edge 1 is the first posedge after this task starts.
  task automatic run_seq(input string name, input int last);
    for (int n = 1; n <= last; n++) begin
      @(negedge Clk);
      nReset = 1'b1;
      SoftReq = 1'b0;
      Ready = ready_at(n);
      @(posedge Clk);
      #1 check($sformatf("%s@%0d", name, n), expect_at(n));
    end
  endtask

  task automatic pulse_soft(input string name, input out_t first_exp);
    @(negedge Clk);
    SoftReq = 1'b1;
    Ready = 4'h0;
    @(posedge Clk);
    #1 check({name, "_sampled"}, first_exp);
    @(negedge Clk);
    SoftReq = 1'b0;
    @(posedge Clk);
    #1 check({name, "_applied"}, RstOut);
  endtask

  initial begin
    vecs[0] = '{"nominal",     '{3, 3, 3, 3},         1'b1, 1'b0, 3'd0};
    vecs[1] = '{"timeout2",    '{3, 3, NEVER, 3},     1'b0, 1'b1, 3'd2};
    vecs[2] = '{"simul",       '{3, RT, 3, -30},      1'b1, 1'b0, 3'd0};
    vecs[3] = '{"minready",    '{1, 1, 1, 1},         1'b1, 1'b0, 3'd0};
    vecs[4] = '{"late0",       '{RT + 1, 3, 3, 3},    1'b0, 1'b1, 3'd0};
    vecs[5] = '{"timeout3",    '{2, 5, 7, NEVER},     1'b0, 1'b1, 3'd3};

    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].name);
      plan(vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
      run_seq(vecs[v].name, end_edge());
      check_bit({vecs[v].name, "_done"}, Done, vecs[v].want_done);
      check_bit({vecs[v].name, "_fault"}, Fault, vecs[v].want_fault);
      checks++;
      if (FaultStage !== vecs[v].want_fs) begin
        errors++;
        $display("FAIL %s_fs: got %0d, want %0d", vecs[v].name, FaultStage, vecs[v].want_fs);
      end
    end

    // SoftReq pulse during stage 1 settle (edges 29..32 of the nominal timeline).
    do_reset("softmid");
    plan(3, 3, 3, 3);
    run_seq("softmid", 29);
    pulse_soft("softmid", expect_at(30));
    run_seq("softmid_reseq", end_edge());
    check_bit("softmid_done", Done, 1'b1);

    // Recovery from FAULT via SoftReq.
    do_reset("faultrec");
    plan(3, 3, NEVER, 3);
    run_seq("faultrec", end_edge());
    pulse_soft("faultrec", expect_at(end_edge() + 1));
    plan(3, 3, 3, 3);
    run_seq("faultrec_reseq", end_edge());
    check_bit("faultrec_done", Done, 1'b1);

    // DONE ignores a later drop of Ready, then a one-cycle nReset restarts the sequence.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      Ready = 4'h0;
      @(posedge Clk);
      #1 check($sformatf("done_hold@%0d", i), DoneOut);
    end
    do_reset("done_nreset");
    plan(3, 3, 3, 3);
    run_seq("done_restart", end_edge());

    // Randomized ready latencies, including early, boundary and missing Ready.
    for (int r = 0; r < 12; r++) begin
      int d [NS];
      for (int i = 0; i < NS; i++) begin
        d[i] = int'($urandom_range(0, 40)) - 4;
        if ($urandom_range(0, 9) == 0) d[i] = NEVER;
      end
      do_reset($sformatf("rand%0d", r));
      plan(d[0], d[1], d[2], d[3]);
      run_seq($sformatf("rand%0d", r), end_edge());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
